// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector: masked, runtime-loadable pattern, selectable
// overlap, a combinational match plus a registered copy and a saturating count.
module mealy_seq_detector #(
    parameter int                PAT_W       = 4,
    parameter int                CNT_W       = 8,
    parameter logic [PAT_W-1:0]  PAT_DEFAULT = PAT_W'(4'b1011)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             count_clr,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_count
);

    localparam int             FW       = $clog2(PAT_W);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] window;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [FW-1:0] sat_inc_fill(input logic [FW-1:0] v);
        return (v == FILL_MAX) ? v : v + FW'(1);
    endfunction

    // Oldest bit in the MSB, the bit arriving this cycle in the LSB.
    assign window = {hist, in};

    assign match = !rst && in_valid && !pat_load && (fill == FILL_MAX) &&
                   (((window ^ pat) & mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat         <= PAT_DEFAULT;
            mask        <= '1;
            hist        <= '0;
            fill        <= '0;
            match_q     <= 1'b0;
            match_count <= '0;
        end else begin
            match_q <= match;

            if (count_clr)
                match_count <= '0;
            else if (match)
                match_count <= sat_inc_cnt(match_count);

            if (pat_load) begin
                pat  <= pat_in;
                mask <= mask_in;
                hist <= '0;
                fill <= '0;
            end else if (in_valid) begin
                // Non-overlapping mode forgets the matched bits by emptying the window.
                hist <= window[PAT_W-2:0];
                if (match && !overlap)
                    fill <= '0;
                else
                    fill <= sat_inc_fill(fill);
            end
        end
    end

endmodule
